// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction-fetch controller owning the PC; one outstanding
//            request, valid/ready handoff, branch/trap/halt sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic        halted,
    output logic        misaligned_fault
);

    localparam logic [1:0] c_BOOT   = 2'd0;
    localparam logic [1:0] c_FETCH  = 2'd1;
    localparam logic [1:0] c_ISSUE  = 2'd2;
    localparam logic [1:0] c_HALTED = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic        r_misaligned;
    logic        r_discard;

    logic [31:0] w_pc_next;
    logic        w_discard_next;
    logic        w_valid_next;
    logic        w_misaligned_next;
    logic        w_load_instr;
    logic        w_bad_target;
    logic        w_req;
    logic        w_halted;

    assign w_bad_target = branch_taken && (branch_target[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a trap pending in FETCH waits for the ack
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_BOOT: begin
                w_state_next = c_FETCH;
            end
            c_FETCH: begin
                if (imem_ack && !(r_discard || trap)) begin
                    w_state_next = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (trap) begin
                    w_state_next = c_FETCH;
                end else if (instr_ready) begin
                    w_state_next = halt ? c_HALTED : c_FETCH;
                end
            end
            c_HALTED: begin
                if (trap || resume) begin
                    w_state_next = c_FETCH;
                end
            end
            default: begin
                w_state_next = c_BOOT;
            end
        endcase
    end

    // Output decode: request and halted depend on state only
    always_comb begin
        w_req             = (r_state == c_FETCH);
        w_halted          = (r_state == c_HALTED);
        w_pc_next         = r_pc;
        w_discard_next    = r_discard;
        w_valid_next      = r_instr_valid;
        w_misaligned_next = 1'b0;
        w_load_instr      = 1'b0;
        case (r_state)
            c_BOOT: begin
                if (trap) begin
                    w_pc_next = TRAP_VECTOR;
                end
            end
            c_FETCH: begin
                if (imem_ack) begin
                    if (r_discard || trap) begin
                        w_pc_next      = TRAP_VECTOR;
                        w_discard_next = 1'b0;
                    end else begin
                        w_load_instr = 1'b1;
                        w_valid_next = 1'b1;
                    end
                end else if (trap) begin
                    w_discard_next = 1'b1;
                end
            end
            c_ISSUE: begin
                if (trap) begin
                    w_valid_next = 1'b0;
                    w_pc_next    = TRAP_VECTOR;
                end else if (instr_ready) begin
                    w_valid_next = 1'b0;
                    if (w_bad_target) begin
                        w_pc_next         = TRAP_VECTOR;
                        w_misaligned_next = 1'b1;
                    end else if (branch_taken) begin
                        w_pc_next = branch_target;
                    end else begin
                        w_pc_next = r_pc + 32'd4;
                    end
                end
            end
            c_HALTED: begin
                if (trap) begin
                    w_pc_next = TRAP_VECTOR;
                end
            end
            default: begin
                w_pc_next = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_VECTOR;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_instr_valid <= 1'b0;
            r_misaligned  <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_instr_valid <= w_valid_next;
            r_misaligned  <= w_misaligned_next;
            r_discard     <= w_discard_next;
            if (w_load_instr) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
        end
    end

    assign imem_req         = w_req;
    assign imem_addr        = r_pc;
    assign pc               = r_pc;
    assign halted           = w_halted;
    assign instr_valid      = r_instr_valid;
    assign instr            = r_instr;
    assign instr_pc         = r_instr_pc;
    assign misaligned_fault = r_misaligned;

endmodule

`default_nettype wire
